neuron_grid_param: RTL and testbench

Parametrised next-generation neuron grid core: on each `tick` it latches one frame of axon spikes and processes every neuron in turn, one axon per cycle. For each connected, spiking axon it adds a signed synaptic weight to the neuron's membrane potential with saturation. It then applies leak, threshold, floor clamp and a selectable reset mode, and emits the updated potential for write-back to the core SRAM. It replaces the fixed 256×256 grid with configurable axon count, neuron count and arithmetic widths, and adds saturation, reset modes, busy-tick error detection and a per-tick spike count.

---
 rtl/neuron_grid_param.sv | 182 ++++++++++++++++++
 tb/tb_neuron_grid_param.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_grid_param.sv
// Parametrised neuron grid core: integrates one spike frame per tick,
// then leaks, fires and emits each neuron's potential for write-back.
module neuron_grid_param #(
  parameter int NUM_AXONS   = 256,
  parameter int NUM_NEURONS = 256,
  parameter int POT_W       = 9,
  parameter int WEIGHT_W    = 9,
  localparam int AW      = $clog2(NUM_AXONS),
  localparam int NW      = $clog2(NUM_NEURONS),
  localparam int CW      = $clog2(NUM_NEURONS + 1),
  localparam int PARAM_W = NUM_AXONS + 5 * WEIGHT_W + 4 * POT_W + 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic [NUM_AXONS-1:0] axon_spikes,
  input  logic [PARAM_W-1:0]   neuron_parameter,
  input  logic [1:0]           neuron_instruction,
  output logic [NW-1:0]        neuron_num,
  output logic [AW-1:0]        axon_num,
  output logic                 scheduler_set,
  output logic                 scheduler_clr,
  output logic                 update_potential,
  output logic [POT_W-1:0]     potential_out,
  output logic                 spike_out,
  output logic [CW-1:0]        spike_count,
  output logic                 done,
  output logic                 error
);

  localparam int GW  = POT_W + 1;
  localparam int OW  = NUM_AXONS;
  localparam int OL  = OW + 4 * WEIGHT_W;
  localparam int OPT = OW + 5 * WEIGHT_W;
  localparam int ONT = OPT + POT_W;
  localparam int ORP = ONT + POT_W;
  localparam int OPO = ORP + POT_W;
  localparam int OMD = OPO + POT_W;

  localparam logic signed [GW-1:0] VMAX =
    {2'b00, {(POT_W-1){1'b1}}};
  localparam logic signed [GW-1:0] VMIN =
    {2'b11, {(POT_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, LOAD, INTEG, LEAK, FIRE, DONE
  } state_t;

  typedef logic signed [POT_W-1:0] pot_t;
  typedef logic signed [GW-1:0]    ext_t;

  function automatic pot_t sat(input ext_t x);
    if (x > VMAX) return VMAX[POT_W-1:0];
    if (x < VMIN) return VMIN[POT_W-1:0];
    return x[POT_W-1:0];
  endfunction

  state_t                 state_q, state_d;
  logic [NUM_AXONS-1:0]   spikes_q;
  logic [AW-1:0]          axon_q;
  logic [NW-1:0]          neuron_q;
  logic [CW-1:0]          count_q;
  logic                   error_q;
  pot_t                   v_q, v_d;
  logic                   upd_q, spk_q;
  pot_t                   pout_q;

  logic [NUM_AXONS-1:0]        conn;
  logic signed [WEIGHT_W-1:0]  w_sel, leak;
  pot_t                        pos_th, neg_th, rst_pot, pot_f;
  logic [1:0]                  mode;
  pot_t                        base, v_leak, v_sub, v_fire, v_out;
  logic                        hit, fire, below, accept, last;

  assign conn    = neuron_parameter[OW-1:0];
  assign leak    = neuron_parameter[OL +: WEIGHT_W];
  assign pos_th  = neuron_parameter[OPT +: POT_W];
  assign neg_th  = neuron_parameter[ONT +: POT_W];
  assign rst_pot = neuron_parameter[ORP +: POT_W];
  assign pot_f   = neuron_parameter[OPO +: POT_W];
  assign mode    = neuron_parameter[OMD +: 2];

  assign accept = (state_q == IDLE) && tick;
  assign last   = neuron_q == NW'(NUM_NEURONS - 1);

  always_comb begin
    w_sel = '0;
    unique case (neuron_instruction)
      2'd0: w_sel = neuron_parameter[OW +: WEIGHT_W];
      2'd1: w_sel = neuron_parameter[OW + WEIGHT_W +: WEIGHT_W];
      2'd2: w_sel = neuron_parameter[OW + 2 * WEIGHT_W +: WEIGHT_W];
      2'd3: w_sel = neuron_parameter[OW + 3 * WEIGHT_W +: WEIGHT_W];
    endcase
  end

  // The stored potential seeds V on the first axon of each neuron.
  always_comb begin
    base   = (axon_q == '0) ? pot_f : v_q;
    hit    = spikes_q[axon_q] & conn[axon_q];
    v_d    = hit ? sat(ext_t'(base) + ext_t'(w_sel)) : base;
    v_leak = sat(ext_t'(v_q) + ext_t'(leak));
    fire   = v_leak >= pos_th;
    below  = v_leak < neg_th;
    v_sub  = sat(ext_t'(v_leak) - ext_t'(pos_th));
    v_fire = v_leak;
    unique case (mode)
      2'd0:    v_fire = rst_pot;
      2'd1:    v_fire = v_sub;
      default: v_fire = v_leak;
    endcase
    v_out = fire ? v_fire : (below ? neg_th : v_leak);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (tick) state_d = LOAD;
      LOAD:  state_d = INTEG;
      INTEG: if (axon_q == AW'(NUM_AXONS - 1)) state_d = LEAK;
      LEAK:  state_d = FIRE;
      FIRE:  state_d = last ? DONE : INTEG;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    scheduler_set = state_q == LOAD;
    scheduler_clr = state_q == DONE;
    done          = state_q == DONE;
  end

  // Fire results are computed at the end of LEAK so they are registered
  // and visible exactly during the FIRE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spikes_q <= '0;
      axon_q   <= '0;
      neuron_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
      v_q      <= '0;
      upd_q    <= 1'b0;
      spk_q    <= 1'b0;
      pout_q   <= '0;
    end else begin
      if (state_q == LOAD) spikes_q <= axon_spikes;
      if (state_q == INTEG) begin
        axon_q <= axon_q + AW'(1);
        v_q    <= v_d;
      end else begin
        axon_q <= '0;
      end
      if (state_q == LEAK) v_q <= v_out;
      if (state_q == LOAD) neuron_q <= '0;
      else if (state_q == FIRE)
        neuron_q <= last ? '0 : neuron_q + NW'(1);
      if (accept) count_q <= '0;
      else if (state_q == LEAK && fire) count_q <= count_q + CW'(1);
      if (accept) error_q <= 1'b0;
      else if (tick && state_q != IDLE) error_q <= 1'b1;
      else if (state_q == LEAK && fire && mode == 2'd3) error_q <= 1'b1;
      upd_q  <= state_q == LEAK;
      spk_q  <= (state_q == LEAK) && fire;
      pout_q <= (state_q == LEAK) ? v_out : '0;
    end
  end

  assign neuron_num       = neuron_q;
  assign axon_num         = axon_q;
  assign spike_count      = count_q;
  assign error            = error_q;
  assign update_potential = upd_q;
  assign spike_out        = spk_q;
  assign potential_out    = pout_q;

endmodule

// File: tb/tb_neuron_grid_param.sv
// Bench for neuron_grid_param: an SRAM model feeds parameters and a
// per-tick arithmetic model predicts every fire and the tick summary.
module tb_neuron_grid_param;

  localparam int A   = 8;
  localparam int N   = 4;
  localparam int PW  = 9;
  localparam int WW  = 9;
  localparam int AW  = $clog2(A);
  localparam int NW  = $clog2(N);
  localparam int CW  = $clog2(N + 1);
  localparam int PRW = A + 5 * WW + 4 * PW + 2;
  localparam int OL  = A + 4 * WW;
  localparam int OPT = A + 5 * WW;
  localparam int ONT = OPT + PW;
  localparam int ORP = ONT + PW;
  localparam int OPO = ORP + PW;
  localparam int OMD = OPO + PW;
  localparam int PER = A + 2;
  localparam int VHI = 2 ** (PW - 1) - 1;
  localparam int VLO = -(2 ** (PW - 1));

  logic           clk = 1'b0;
  logic           reset, tick;
  logic [A-1:0]   axon_spikes;
  logic [PRW-1:0] prm;
  logic [1:0]     ins;
  logic [NW-1:0]  neuron_num;
  logic [AW-1:0]  axon_num;
  logic           scheduler_set, scheduler_clr, update_potential;
  logic [PW-1:0]  potential_out;
  logic           spike_out, done, error;
  logic [CW-1:0]  spike_count;

  logic [A-1:0] conn_m[N];
  int           w_m[N][4];
  int           leak_m[N], pth_m[N], nth_m[N], rp_m[N], pot_m[N], mode_m[N];
  logic [1:0]   ins_m[N][A];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  neuron_grid_param #(
    .NUM_AXONS(A), .NUM_NEURONS(N), .POT_W(PW), .WEIGHT_W(WW)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .axon_spikes(axon_spikes),
    .neuron_parameter(prm),
    .neuron_instruction(ins),
    .neuron_num(neuron_num), .axon_num(axon_num),
    .scheduler_set(scheduler_set), .scheduler_clr(scheduler_clr),
    .update_potential(update_potential),
    .potential_out(potential_out), .spike_out(spike_out),
    .spike_count(spike_count), .done(done), .error(error)
  );

  always_comb begin
    prm = '0;
    prm[A-1:0] = conn_m[neuron_num];
    for (int i = 0; i < 4; i++)
      prm[A + i * WW +: WW] = WW'(w_m[neuron_num][i]);
    prm[OL +: WW]  = WW'(leak_m[neuron_num]);
    prm[OPT +: PW] = PW'(pth_m[neuron_num]);
    prm[ONT +: PW] = PW'(nth_m[neuron_num]);
    prm[ORP +: PW] = PW'(rp_m[neuron_num]);
    prm[OPO +: PW] = PW'(pot_m[neuron_num]);
    prm[OMD +: 2]  = 2'(mode_m[neuron_num]);
    ins = ins_m[neuron_num][axon_num];
  end

  function automatic int sat(input int x);
    if (x > VHI) return VHI;
    if (x < VLO) return VLO;
    return x;
  endfunction

  function automatic int srnd(input int lo, input int hi);
    return lo + int'($urandom_range(hi - lo));
  endfunction

  task automatic set_all(input logic [A-1:0] c, input int w,
                         input int lk, input int pth, input int nth,
                         input int rp, input int pot, input int md);
    for (int n = 0; n < N; n++) begin
      conn_m[n] = c;
      for (int i = 0; i < 4; i++) w_m[n][i] = w;
      leak_m[n] = lk; pth_m[n] = pth; nth_m[n] = nth;
      rp_m[n] = rp; pot_m[n] = pot; mode_m[n] = md;
      for (int a = 0; a < A; a++) ins_m[n][a] = 2'($urandom_range(3));
    end
  endtask

  task automatic randomize_grid();
    for (int n = 0; n < N; n++) begin
      conn_m[n] = A'($urandom);
      for (int i = 0; i < 4; i++) w_m[n][i] = srnd(-80, 80);
      leak_m[n] = srnd(-10, 10);
      pth_m[n]  = srnd(0, 200);
      nth_m[n]  = srnd(-200, 0);
      rp_m[n]   = srnd(-50, 50);
      pot_m[n]  = srnd(-100, 100);
      mode_m[n] = int'($urandom_range(3));
      for (int a = 0; a < A; a++) ins_m[n][a] = 2'($urandom_range(3));
    end
  endtask

  function automatic bit all_zero();
    return update_potential === 1'b0 && spike_out === 1'b0 &&
      potential_out === '0 && neuron_num === '0 &&
      axon_num === '0 && spike_count === '0 && done === 1'b0 &&
      error === 1'b0 && scheduler_set === 1'b0 &&
      scheduler_clr === 1'b0;
  endfunction

  task automatic run_tick(input logic [A-1:0] sp, input int inj_c,
                          input int abort_c);
    int  ev[N];
    bit  es[N];
    int  cnt, dc, strays, nfire;
    bit  merr, experr;
    cnt = 0; merr = 0; strays = 0; nfire = N;
    for (int n = 0; n < N; n++) begin
      int v;
      v = pot_m[n];
      for (int a = 0; a < A; a++)
        if (sp[a] && conn_m[n][a]) v = sat(v + w_m[n][ins_m[n][a]]);
      v = sat(v + leak_m[n]);
      es[n] = v >= pth_m[n];
      if (es[n]) begin
        cnt++;
        if (mode_m[n] == 0) v = rp_m[n];
        else if (mode_m[n] == 1) v = sat(v - pth_m[n]);
        if (mode_m[n] == 3) merr = 1;
      end else if (v < nth_m[n]) begin
        v = nth_m[n];
      end
      ev[n] = v;
    end
    experr = merr || (inj_c >= 0);
    dc = N * PER + 1;
    @(negedge clk);
    axon_spikes = sp;
    tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    for (int c = 0; c <= dc + 1; c++) begin
      @(negedge clk);
      if (c == abort_c) begin
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (!all_zero()) begin
          n_fail++;
          $display("FAIL async_reset: upd=%b pot=%0d nn=%0d an=%0d done=%b err=%b, required all 0",
                   update_potential, potential_out, neuron_num,
                   axon_num, done, error);
        end
        nfire = abort_c / PER;
        break;
      end
      if (c == 0) begin
        n_checks++;
        if (scheduler_set !== 1'b1) begin
          n_fail++;
          $display("FAIL sched_set: got %b required 1", scheduler_set);
        end
      end
      if (c == 1) begin
        n_checks++;
        if (error !== 1'b0) begin
          n_fail++;
          $display("FAIL error_clear: got %b required 0", error);
        end
      end
      if (c > 0 && c % PER == 0 && c <= N * PER) begin
        int n;
        n = c / PER - 1;
        n_checks++;
        if (update_potential !== 1'b1 || neuron_num !== NW'(n)) begin
          n_fail++;
          $display("FAIL fire_strobe n%0d: upd=%b nn=%0d required 1/%0d",
                   n, update_potential, neuron_num, n);
        end
        n_checks++;
        if (int'($signed(potential_out)) !== ev[n]) begin
          n_fail++;
          $display("FAIL potential n%0d: got %0d required %0d",
                   n, $signed(potential_out), ev[n]);
        end
        n_checks++;
        if (spike_out !== es[n]) begin
          n_fail++;
          $display("FAIL spike n%0d: got %b required %b",
                   n, spike_out, es[n]);
        end
      end else if (update_potential !== 1'b0 || spike_out !== 1'b0 ||
                   potential_out !== '0) begin
        strays++;
      end
      if (c == dc) begin
        n_checks++;
        if (done !== 1'b1 || scheduler_clr !== 1'b1) begin
          n_fail++;
          $display("FAIL done_timing: done=%b clr=%b required 1/1",
                   done, scheduler_clr);
        end
        n_checks++;
        if (spike_count !== CW'(cnt)) begin
          n_fail++;
          $display("FAIL spike_count: got %0d required %0d",
                   spike_count, cnt);
        end
        n_checks++;
        if (error !== experr) begin
          n_fail++;
          $display("FAIL error_at_done: got %b required %b",
                   error, experr);
        end
      end else if (done !== 1'b0 || scheduler_clr !== 1'b0) begin
        strays++;
      end
      if (inj_c >= 0 && c == inj_c + 1) begin
        n_checks++;
        if (error !== 1'b1) begin
          n_fail++;
          $display("FAIL busy_tick_error: got %b required 1", error);
        end
      end
      tick = (c == inj_c);
    end
    tick = 1'b0;
    n_checks++;
    if (strays != 0) begin
      n_fail++;
      $display("FAIL stray_strobes: got %0d cycles required 0", strays);
    end
    for (int n = 0; n < nfire; n++) pot_m[n] = ev[n];
  endtask

  task automatic test_reset();
    reset = 1'b1; tick = 1'b0; axon_spikes = '0;
    set_all('0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (!all_zero()) begin
      n_fail++;
      $display("FAIL reset_state: upd=%b nn=%0d cnt=%0d err=%b required 0",
               update_potential, neuron_num, spike_count, error);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (!all_zero()) begin
      n_fail++;
      $display("FAIL idle_after_reset: upd=%b done=%b required 0",
               update_potential, done);
    end
  endtask

  task automatic test_basic();
    set_all('1, 1, 0, 100, -100, 0, 0, 0);
    run_tick(8'b0101_0101, -1, -1);
    n_checks++;
    if (pot_m[0] !== 4 || pot_m[N-1] !== 4) begin
      n_fail++;
      $display("FAIL basic_model: got %0d/%0d required 4/4",
               pot_m[0], pot_m[N-1]);
    end
    run_tick(8'b1111_0000, -1, -1);
    run_tick(A'($urandom), -1, -1);
  endtask

  task automatic test_saturation();
    set_all('1, 255, 0, 255, -100, 0, 200, 2);
    run_tick('1, -1, -1);
    set_all('1, -256, 0, 255, -100, 0, 200, 0);
    run_tick('1, -1, -1);
    set_all('1, 200, 100, 255, -100, 0, 250, 1);
    run_tick('1, -1, -1);
  endtask

  task automatic test_modes();
    for (int m = 0; m < 4; m++) begin
      set_all('1, 1, 0, 10, -100, -3, 5, m);
      run_tick('1, -1, -1);
    end
    set_all('1, 1, 0, 10, -100, -3, 5, 0);
    run_tick(8'b0000_0011, -1, -1);
  endtask

  task automatic test_busy_tick();
    randomize_grid();
    run_tick(A'($urandom), 5, -1);
    run_tick(A'($urandom), PER + 4, -1);
    run_tick(A'($urandom), -1, -1);
  endtask

  task automatic test_reset_mid();
    int strays;
    randomize_grid();
    run_tick(A'($urandom), -1, PER + 3);
    strays = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3 * PER; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || update_potential !== 1'b0) strays++;
    end
    n_checks++;
    if (strays != 0) begin
      n_fail++;
      $display("FAIL post_reset_quiet: got %0d strobes required 0", strays);
    end
    run_tick(A'($urandom), -1, -1);
  endtask

  task automatic test_random();
    randomize_grid();
    for (int t = 0; t < 16; t++) run_tick(A'($urandom), -1, -1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_modes();
    test_busy_tick();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
